instr_bundle_encoder: RTL and testbench

- Field-to-word encoder for the dual-issue front end: the inverse of the instruction decode function.
- Accepts decoded field bundles (op, rd, rs1, rs2, funct3, funct7, imm12, imm20) one per handshake and re-encodes each into a 32-bit instruction word.
- Pairs consecutive words into A/B issue bundles and buffers them in a small FIFO.
- Feeds the instruction-memory loader, and lets the bench round-trip decode → encode.

---
 rtl/instr_bundle_encoder_if.sv | 36 +++
 rtl/instr_bundle_encoder.sv | 152 +++++++++++++++
 tb/tb_instr_bundle_encoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_bundle_encoder_if.sv
// Handshake and bundle-output signals for instr_bundle_encoder.
// The master modport drives field bundles and consumes issue bundles; slave is the encoder.
interface instr_bundle_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [11:0] in_imm12;
    logic [19:0] in_imm20;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr_a;
    logic [31:0] out_instr_b;
    logic        out_b_valid;
    logic [31:0] out_pc;
    logic [7:0]  err_count;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm12, in_imm20, flush, out_ready,
        input  in_ready, out_valid, out_instr_a, out_instr_b, out_b_valid,
               out_pc, err_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm12, in_imm20, flush, out_ready,
        output in_ready, out_valid, out_instr_a, out_instr_b, out_b_valid,
               out_pc, err_count
    );
endinterface

// File: rtl/instr_bundle_encoder.sv
// Re-encodes decoded field bundles into 32-bit instruction words, pairs them
// into A/B issue bundles tagged with a PC, and queues the bundles in a FIFO.
module instr_bundle_encoder #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   rst_n,
    instr_bundle_encoder_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_S    = 7'b0100011;
    localparam logic [6:0]  OP_B    = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;

    typedef enum logic {SLOT_A, SLOT_B} state_e;

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     pc_q;
    logic [7:0]      err_q;
    logic [31:0]     mem_a_q  [DEPTH];
    logic [31:0]     mem_b_q  [DEPTH];
    logic            mem_bv_q [DEPTH];
    logic [31:0]     mem_pc_q [DEPTH];

    logic [31:0] enc_word;
    logic        enc_unknown;
    logic        full, pop, can_push, ready, accept, push, push_bv;
    logic [31:0] push_a, push_b;

    always_comb begin
        enc_word    = NOP;
        enc_unknown = 1'b0;
        case (bus.in_op)
            OP_R:            enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                                         bus.in_funct3, bus.in_rd, bus.in_op};
            OP_LOAD, OP_IMM: enc_word = {bus.in_imm12, bus.in_rs1, bus.in_funct3,
                                         bus.in_rd, bus.in_op};
            OP_S:            enc_word = {bus.in_imm12[11:5], bus.in_rs2, bus.in_rs1,
                                         bus.in_funct3, bus.in_imm12[4:0], bus.in_op};
            OP_B:            enc_word = {bus.in_imm12[11], bus.in_imm12[9:4], bus.in_rs2,
                                         bus.in_rs1, bus.in_funct3, bus.in_imm12[3:0],
                                         bus.in_imm12[10], bus.in_op};
            OP_JAL:          enc_word = {bus.in_imm20[19], bus.in_imm20[10:0],
                                         bus.in_imm20[11], bus.in_imm20[18:12],
                                         bus.in_rd, bus.in_op};
            default:         enc_unknown = 1'b1;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        pop      = (count_q != '0) && bus.out_ready;
        can_push = !full || pop;
        state_d  = state_q;
        a_d      = a_q;
        ready    = 1'b1;
        accept   = 1'b0;
        push     = 1'b0;
        push_a   = a_q;
        push_b   = NOP;
        push_bv  = 1'b0;
        case (state_q)
            SLOT_A: begin
                ready  = !bus.flush || can_push;
                accept = bus.in_valid && ready;
                if (accept) begin
                    if (bus.flush) begin
                        push   = 1'b1;
                        push_a = enc_word;
                    end else begin
                        a_d     = enc_word;
                        state_d = SLOT_B;
                    end
                end
            end
            SLOT_B: begin
                ready  = can_push;
                accept = bus.in_valid && ready;
                if (accept) begin
                    push    = 1'b1;
                    push_b  = enc_word;
                    push_bv = 1'b1;
                    state_d = SLOT_A;
                end else if (bus.flush && can_push) begin
                    push    = 1'b1;
                    state_d = SLOT_A;
                end
            end
            default: state_d = SLOT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SLOT_A;
            a_q      <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pc_q     <= RESET_PC;
            err_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a_q[i]  <= '0;
                mem_b_q[i]  <= '0;
                mem_bv_q[i] <= 1'b0;
                mem_pc_q[i] <= RESET_PC;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            if (push) begin
                mem_a_q[wr_ptr_q]  <= push_a;
                mem_b_q[wr_ptr_q]  <= push_b;
                mem_bv_q[wr_ptr_q] <= push_bv;
                mem_pc_q[wr_ptr_q] <= pc_q;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
                pc_q               <= pc_q + 32'd8;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (accept && enc_unknown && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_instr_a = mem_a_q[rd_ptr_q];
    assign bus.out_instr_b = mem_b_q[rd_ptr_q];
    assign bus.out_b_valid = mem_bv_q[rd_ptr_q];
    assign bus.out_pc      = mem_pc_q[rd_ptr_q];
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_instr_bundle_encoder.sv
// Self-checking bench for instr_bundle_encoder: directed scenarios plus random
// traffic compared against a queue-based bundle model.
module tb_instr_bundle_encoder;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm12;
        logic [19:0] imm20;
    } fields_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bv;
        logic [31:0] pc;
    } bundle_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bundle_t     q[$];
    logic [31:0] pend[$];
    logic [31:0] m_pc;
    int          m_err;

    instr_bundle_encoder_if bus ();

    instr_bundle_encoder #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit known(logic [6:0] op);
        return op == 7'h33 || op == 7'h03 || op == 7'h13 || op == 7'h23 ||
               op == 7'h63 || op == 7'h6F;
    endfunction

    // Field placement written as shifted OR terms, straight from the bit maps.
    function automatic logic [31:0] ref_encode(fields_t f);
        logic [31:0] w;
        w = 32'(f.op);
        case (f.op)
            7'h33: w = w | (32'(f.f7) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15)
                         | (32'(f.f3) << 12) | (32'(f.rd) << 7);
            7'h03, 7'h13: w = w | (32'(f.imm12) << 20) | (32'(f.rs1) << 15)
                         | (32'(f.f3) << 12) | (32'(f.rd) << 7);
            7'h23: w = w | (32'(f.imm12 >> 5) << 25) | (32'(f.rs2) << 20)
                         | (32'(f.rs1) << 15) | (32'(f.f3) << 12) | (32'(f.imm12 & 12'h1F) << 7);
            7'h63: w = w | (32'(f.imm12[11]) << 31) | (32'(f.imm12[10]) << 7)
                         | (32'((f.imm12 >> 4) & 12'h3F) << 25) | (32'(f.imm12 & 12'hF) << 8)
                         | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12);
            7'h6F: w = w | (32'(f.imm20[19]) << 31) | (32'((f.imm20 >> 12) & 20'h7F) << 12)
                         | (32'(f.imm20[11]) << 19) | (32'(f.imm20 & 20'h7FF) << 20)
                         | (32'(f.rd) << 7);
            default: w = NOP;
        endcase
        return w;
    endfunction

    function automatic fields_t rnd_fields(logic [6:0] op);
        fields_t f;
        f.op    = op;
        f.rd    = 5'($urandom);
        f.rs1   = 5'($urandom);
        f.rs2   = 5'($urandom);
        f.f3    = 3'($urandom);
        f.f7    = 7'($urandom);
        f.imm12 = 12'($urandom);
        f.imm20 = 20'($urandom);
        return f;
    endfunction

    function automatic logic [6:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 7'h33;
            1: return 7'h03;
            2: return 7'h13;
            3: return 7'h23;
            4: return 7'h63;
            5: return 7'h6F;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_bundle(logic [31:0] a, logic [31:0] b, logic bv);
        bundle_t e;
        e.a  = a;
        e.b  = b;
        e.bv = bv;
        e.pc = m_pc;
        q.push_back(e);
        m_pc = m_pc + 32'd8;
        pend.delete();
    endtask

    // One clock: drive at negedge, check at negedge+1, advance the model to the next posedge.
    task automatic cycle(logic v, fields_t f, logic fl, logic ordy);
        bit full, pop, canp, exp_rdy, acc;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_op     = f.op;
        bus.in_rd     = f.rd;
        bus.in_rs1    = f.rs1;
        bus.in_rs2    = f.rs2;
        bus.in_funct3 = f.f3;
        bus.in_funct7 = f.f7;
        bus.in_imm12  = f.imm12;
        bus.in_imm20  = f.imm20;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        full    = (q.size() == DEPTH);
        pop     = (q.size() != 0) && ordy;
        canp    = !full || pop;
        exp_rdy = (pend.size() == 0) ? (!fl || canp) : canp;
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
        check("err_count", {24'b0, bus.err_count}, 32'(m_err));
        if (q.size() != 0) begin
            check("head_a", bus.out_instr_a, q[0].a);
            check("head_b", bus.out_instr_b, q[0].b);
            check("head_bv", {31'b0, bus.out_b_valid}, {31'b0, q[0].bv});
            check("head_pc", bus.out_pc, q[0].pc);
        end
        acc = v && exp_rdy;
        if (pop) void'(q.pop_front());
        if (acc) begin
            pend.push_back(ref_encode(f));
            if (!known(f.op) && m_err < 255) m_err++;
        end
        if (pend.size() == 2) push_bundle(pend[0], pend[1], 1'b1);
        else if (fl && pend.size() == 1 && canp) push_bundle(pend[0], NOP, 1'b0);
    endtask

    task automatic idle(int n, logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, ordy);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_a"}, bus.out_instr_a, 32'd0);
        check({tag, "_b"}, bus.out_instr_b, 32'd0);
        check({tag, "_bv"}, {31'b0, bus.out_b_valid}, 32'd0);
        check({tag, "_pc"}, bus.out_pc, RESET_PC);
        check({tag, "_err"}, {24'b0, bus.err_count}, 32'd0);
        check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        fields_t     f_add, f_lw, f_sw, f_b, f_j;
        logic [31:0] w;
        tests = 0;
        fails = 0;
        m_pc  = RESET_PC;
        m_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_imm12 = '0; bus.in_imm20 = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        f_add = '{op: 7'h33, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7: 7'd0, imm12: '0, imm20: '0};
        f_lw  = '{op: 7'h03, rd: 5'd5, rs1: 5'd2, rs2: 5'd0, f3: 3'd2, f7: 7'd0, imm12: 12'd8, imm20: '0};
        f_sw  = '{op: 7'h23, rd: 5'd0, rs1: 5'd2, rs2: 5'd6, f3: 3'd2, f7: 7'd0, imm12: 12'd4, imm20: '0};
        f_b   = '{op: 7'h63, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7: 7'd0, imm12: 12'h801, imm20: '0};
        f_j   = '{op: 7'h6F, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm12: '0, imm20: 20'hFFFFF};

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD + LW pair
        cycle(1'b1, f_add, 1'b0, 1'b0);
        cycle(1'b1, f_lw, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("addlw_a", bus.out_instr_a, 32'h002081B3);
        check("addlw_b", bus.out_instr_b, 32'h00812283);
        check("addlw_bv", {31'b0, bus.out_b_valid}, 32'd1);
        check("addlw_pc", bus.out_pc, 32'h0);

        // SW closed by flush
        cycle(1'b1, f_sw, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("sw_a", bus.out_instr_a, 32'h00612223);
        check("sw_b", bus.out_instr_b, NOP);
        check("sw_bv", {31'b0, bus.out_b_valid}, 32'd0);
        check("sw_pc", bus.out_pc, 32'h8);

        // B_TYPE + JAL, then decode them back
        cycle(1'b1, f_b, 1'b0, 1'b0);
        cycle(1'b1, f_j, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("bj_a", bus.out_instr_a, 32'h80208163);
        check("bj_b", bus.out_instr_b, 32'hFFFFF0EF);
        w = bus.out_instr_a;
        check("dec_b_imm", 32'({w[31], w[7], w[30:25], w[11:8]}), 32'(f_b.imm12));
        check("dec_b_regs", 32'({w[24:20], w[19:15], w[14:12]}), 32'({f_b.rs2, f_b.rs1, f_b.f3}));
        w = bus.out_instr_b;
        check("dec_j_imm", 32'({w[31], w[18:12], w[19], w[30:20]}), 32'(f_j.imm20));
        check("dec_j_rd", 32'(w[11:7]), 32'(f_j.rd));
        idle(2, 1'b1);

        // Fill the FIFO, then pop and push in the same cycle
        for (int i = 0; i < 2 * DEPTH + 1; i++) cycle(1'b1, rnd_fields(rnd_op()), 1'b0, 1'b0);
        cycle(1'b1, rnd_fields(7'h33), 1'b0, 1'b0);
        check("full_slotb_ready", {31'b0, bus.in_ready}, 32'd0);
        cycle(1'b1, rnd_fields(7'h13), 1'b0, 1'b1);
        check("full_pop_ready", {31'b0, bus.in_ready}, 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Unknown opcodes: 300 bundles of NOPs, counter saturates
        for (int i = 0; i < 600; i++) cycle(1'b1, rnd_fields(7'h7F), 1'b0, 1'b1);
        idle(2, 1'b1);
        check("err_sat", {24'b0, bus.err_count}, 32'd255);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 7, rnd_fields(rnd_op()),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
        idle(DEPTH + 2, 1'b1);

        // Asynchronous reset in SLOT_B with two bundles queued
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd_fields(rnd_op()), 1'b0, 1'b0);
        @(posedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        q.delete();
        pend.delete();
        m_pc  = RESET_PC;
        m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, f_lw, 1'b0, 1'b0);
        cycle(1'b1, f_add, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_rst_a", bus.out_instr_a, 32'h00812283);
        check("post_rst_b", bus.out_instr_b, 32'h002081B3);
        check("post_rst_pc", bus.out_pc, RESET_PC);
        idle(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
